// File: rtl/pos_cell_mem.sv
// pos_cell_mem: particle position store, 2-cycle pipelined read port plus an append port.
// Define POS_CELL_DBUF_EN for active/shadow double buffering; otherwise a single bank is appended in place.
module pos_cell_mem #(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8,
    parameter int INIT_COUNT   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  swap,
    output logic [ADDR_WIDTH-1:0] particle_num,
    output logic                  wr_full,
    output logic                  overflow
);

    localparam logic [ADDR_WIDTH-1:0] FULL_PTR = ADDR_WIDTH'(PARTICLE_NUM);
    localparam logic [ADDR_WIDTH-1:0] INIT_NUM = ADDR_WIDTH'(INIT_COUNT);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] commit_num;
    logic                  wr_accept;
    logic                  wr_drop;
    logic                  rd_hit;

    logic                  s1_valid;
    logic                  s1_hit;
    logic [DATA_WIDTH-1:0] s1_data;

    assign wr_full    = (wr_ptr == FULL_PTR);
    assign wr_accept  = wr_en && !wr_full && !rst;
    assign wr_drop    = wr_en && wr_full;
    // A write accepted in the swap cycle belongs to the bank being committed.
    assign commit_num = wr_accept ? (wr_ptr + ADDR_WIDTH'(1)) : wr_ptr;
    assign rd_hit     = rd_en && (rd_addr < particle_num);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            particle_num <= INIT_NUM;
            overflow     <= 1'b0;
        end else begin
            if (swap) begin
                wr_ptr       <= '0;
                particle_num <= commit_num;
            end else if (wr_accept) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (wr_drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef POS_CELL_DBUF_EN
    logic                  bank_sel;
    logic [DATA_WIDTH-1:0] mem0 [PARTICLE_NUM];
    logic [DATA_WIDTH-1:0] mem1 [PARTICLE_NUM];

    // bank_sel names the readable bank; appends always target the other one.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_sel <= 1'b0;
        end else if (swap) begin
            bank_sel <= ~bank_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            if (bank_sel) begin
                mem0[wr_ptr] <= wr_data;
            end else begin
                mem1[wr_ptr] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_hit) begin
            s1_data <= bank_sel ? mem1[rd_addr] : mem0[rd_addr];
        end
    end
`else
    logic [DATA_WIDTH-1:0] mem [PARTICLE_NUM];

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_hit) begin
            s1_data <= mem[rd_addr];
        end
    end
`endif

    // rd_valid is a one-cycle qualifier with no backpressure: rd_en accepted at edge N
    // presents rd_valid/rd_data after edge N+1; rd_data is zero whenever rd_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_hit   <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            s1_valid <= rd_en;
            s1_hit   <= rd_hit;
            rd_valid <= s1_valid;
            rd_data  <= s1_hit ? s1_data : '0;
        end
    end

endmodule

// File: doc/pos_cell_mem.md
POS_CELL_MEM -- requirements
Module: pos_cell_mem

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 96, meaning the word width, packed MSB-LSB as {posz, posy, posx}, 32 bits each.
REQ-002 SHALL have parameter PARTICLE_NUM, default 220, meaning the words per bank.
REQ-003 SHALL have parameter ADDR_WIDTH, default 8, meaning the address and count width; it SHALL satisfy 2**ADDR_WIDTH > PARTICLE_NUM.
REQ-004 SHALL have parameter INIT_COUNT, default 0, meaning the valid particles preloaded in bank 0 by the init file.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  sole clock; all state updates on the rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 rd_en  in  1  read request.
REQ-009 rd_addr  in  ADDR_WIDTH  particle index within the active bank.
REQ-010 rd_data  out  DATA_WIDTH  read result.
REQ-011 rd_valid  out  1  rd_data qualifier.
REQ-012 wr_en  in  1  append request into the write bank.
REQ-013 wr_data  in  DATA_WIDTH  position to append.
REQ-014 swap  in  1  commit the write bank and make it active.
REQ-015 particle_num  out  ADDR_WIDTH  valid-particle count of the active bank.
REQ-016 wr_full  out  1  write pointer equals PARTICLE_NUM.
REQ-017 overflow  out  1  sticky flag, set when an append is dropped.

Function
REQ-018 Storage SHALL be two banks of PARTICLE_NUM x DATA_WIDTH: one active (read) bank and one shadow (write) bank; no count word is stored in memory.
REQ-019 Read latency SHALL be exactly 2 cycles: rd_en=1 at edge N gives rd_valid=1 and rd_data at edge N+2; it is fully pipelined, one read per cycle.
REQ-020 A read with rd_addr >= particle_num (sampled at issue) SHALL return rd_data=0 with rd_valid=1.
REQ-021 rd_valid=0 SHALL force rd_data=0.
REQ-022 wr_en=1 with wr_full=0 SHALL write wr_data to shadow[wr_ptr] and increment wr_ptr by 1.
REQ-023 wr_en=1 with wr_full=1 SHALL leave memory unchanged and SHALL set overflow.
REQ-024 overflow SHALL hold until rst.
REQ-025 wr_full SHALL be combinational from wr_ptr == PARTICLE_NUM.
REQ-026 swap=1 SHALL apply the following on the next edge:
- toggle bank select;
- particle_num <= committed pointer;
- wr_ptr <= 0;
- wr_full deasserts.
REQ-027 Simultaneous wr_en and swap: an accepted write SHALL land in the bank being committed, and the committed count SHALL include it (wr_ptr+1).
REQ-028 Simultaneous rd_en and swap: the read SHALL use the pre-swap bank and pre-swap particle_num; reads already in the pipeline SHALL complete unaffected.
REQ-029 swap with wr_ptr=0 SHALL commit an empty bank, giving particle_num=0.
REQ-030 Writes SHALL never alter active-bank contents while double buffering is enabled.

Reset
REQ-031 rst SHALL set the following:
- rd_valid=0, rd_data=0;
- wr_ptr=0, overflow=0;
- bank select=bank 0 active;
- particle_num=INIT_COUNT.
REQ-032 Memory contents SHALL NOT be cleared by rst.
REQ-033 rst asserted mid-operation SHALL discard in-flight reads: rd_valid=0 on the cycle after rst and the cycle after that.
REQ-034 rst asserted mid-operation SHALL discard pending appends.
REQ-035 rst SHALL override concurrent wr_en and swap.

Configuration
REQ-036 Macro POS_CELL_DBUF_EN defined SHALL give the two-bank behaviour above.
REQ-037 Without POS_CELL_DBUF_EN, a single bank SHALL be instantiated:
- appends write in place at wr_ptr, and are visible to reads at addresses < particle_num;
- swap only performs particle_num <= committed pointer and wr_ptr <= 0;
- bank select is absent.
- All other requirements apply unchanged.

Verification
REQ-038 Reset with INIT_COUNT=5, read addr 0..6 back-to-back -> 7 consecutive rd_valid pulses starting 2 cycles after the first request; addr 0..4 return init data, addr 5..6 return 0.
REQ-039 Append 3 words (A, B, C), then read addr 0 before any swap -> the init-file word is returned and particle_num stays 5. Then pulse swap -> particle_num=3, and addr 0..2 return A, B, C.
REQ-040 Append 220 words, then 1 more -> wr_full=1 after the 220th, and the 221st sets overflow=1. After swap, particle_num=220 and word 219 reads correctly.
REQ-041 wr_en with D on the same cycle as swap, with wr_ptr=2 -> particle_num=3 and addr 2 returns D. A read issued in the swap cycle returns old-bank data.
REQ-042 rst asserted one cycle after a rd_en -> no rd_valid pulse. After reset, particle_num=INIT_COUNT, overflow=0, and the next append lands at index 0.
REQ-043 Without POS_CELL_DBUF_EN, INIT_COUNT=4: append X, then read addr 0 -> X, with particle_num still 4.
